// File: rtl/ahb_simple_pkg.sv
// Shared definitions for the AHB-Lite to simple-bus bridge: AHB encodings and bridge FSM states.
package ahb_simple_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_DONE,
    ERR1,
    ERR2
  } bridge_state_t;

endpackage

// File: rtl/ahb2simple_bridge.sv
// AHB-Lite slave that turns bus transfers into addr/we/wd/rd peripheral accesses.
// Writes complete with zero wait states; reads insert RD_WAIT wait states.
// Optional feature macro: AHB2SIMPLE_ERR_EN (non-word or misaligned transfers get a two-cycle ERROR).
module ahb2simple_bridge #(
  parameter int RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] addr,
  output logic        we,
  output logic [31:0] wd,
  input  logic [31:0] rd
);
  import ahb_simple_pkg::*;

  // The RD_WAIT parameter hides the same-named state, so that state is always package-qualified.
  localparam logic [3:0] CNT_LOAD = 4'(RD_WAIT - 1);

  bridge_state_t state;
  logic [3:0]    cnt;
  logic [31:0]   addr_r;
  logic [31:0]   hrdata_r;
  logic          accept;
  logic          bad_xfer;

  // Stalled states never accept, even if an upstream master misbehaves while we hold hreadyout low.
  assign hreadyout = (state != ahb_simple_pkg::RD_WAIT) && (state != ERR1);
  assign accept    = hsel && hready && htrans[1] && hreadyout;

  assign addr   = addr_r;
  assign wd     = hwdata;
  assign we     = (state == WR);
  assign hrdata = hrdata_r;

`ifdef AHB2SIMPLE_ERR_EN
  assign bad_xfer = (hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00);
  assign hresp    = (state == ERR1) || (state == ERR2);
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{hsize, htrans[0]};
  assign bad_xfer = 1'b0;
  assign hresp    = 1'b0;
`endif

  // Bridge FSM with its read wait counter, address latch and read data capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_r   <= 32'd0;
      hrdata_r <= 32'd0;
    end else begin
      case (state)
        ahb_simple_pkg::RD_WAIT: begin
          if (cnt == 4'd0) begin
            hrdata_r <= rd;
            state    <= RD_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef AHB2SIMPLE_ERR_EN
        ERR1: begin
          state <= ERR2;
        end
`endif
        default: begin
          if (accept) begin
            addr_r <= haddr;
            if (bad_xfer) begin
              state <= ERR1;
            end else if (hwrite) begin
              state <= WR;
            end else begin
              state <= ahb_simple_pkg::RD_WAIT;
              cnt   <= CNT_LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2simple_bridge.sv
// Directed self-checking bench for ahb2simple_bridge.
// dut_a uses one read wait state, dut_b uses three; each has its own hsel so they can be exercised separately.
module tb_ahb2simple_bridge;

  logic        clk;
  logic        resetn;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;

  logic [31:0] hrdata_a, addr_a, wd_a, rd_a;
  logic        hreadyout_a, hresp_a, we_a;
  logic [31:0] hrdata_b, addr_b, wd_b, rd_b;
  logic        hreadyout_b, hresp_b, we_b;

  int n_checks;
  int n_pass;

  // Peripheral model: read data is a fixed function of the address.
  assign rd_a = addr_a ^ 32'h0000_005A;
  assign rd_b = addr_b ^ 32'h0000_005A;

  ahb2simple_bridge #(.RD_WAIT(1)) dut_a (
    .clk(clk), .resetn(resetn), .hsel(hsel_a), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata_a), .hreadyout(hreadyout_a), .hresp(hresp_a),
    .addr(addr_a), .we(we_a), .wd(wd_a), .rd(rd_a)
  );

  ahb2simple_bridge #(.RD_WAIT(3)) dut_b (
    .clk(clk), .resetn(resetn), .hsel(hsel_b), .haddr(haddr), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata_b), .hreadyout(hreadyout_b), .hresp(hresp_b),
    .addr(addr_b), .we(we_b), .wd(wd_b), .rd(rd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one bus cycle just after the rising edge: address phase fields plus data-phase hwdata.
  task automatic drive(input logic sa, input logic sb, input logic [31:0] a, input logic w,
                       input logic [1:0] t, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    hsel_a = sa;
    hsel_b = sb;
    haddr  = a;
    hwrite = w;
    htrans = t;
    hwdata = wdata;
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (hrdata_a !== 32'd0) $display("FAIL reset_hrdata: got %h want 0", hrdata_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL reset_hreadyout: got %b want 1", hreadyout_a); else n_pass++;
    n_checks++; if (hresp_a !== 1'b0) $display("FAIL reset_hresp: got %b want 0", hresp_a); else n_pass++;
    n_checks++; if (addr_a !== 32'd0) $display("FAIL reset_addr: got %h want 0", addr_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0) $display("FAIL reset_we: got %b want 0", we_a); else n_pass++;
    n_checks++; if (hreadyout_b !== 1'b1) $display("FAIL reset_hreadyout_b: got %b want 1", hreadyout_b); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'hA5);
    @(negedge clk);
    n_checks++; if (we_a !== 1'b1) $display("FAIL wr_we: got %b want 1", we_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h0) $display("FAIL wr_addr: got %h want 0", addr_a); else n_pass++;
    n_checks++; if (wd_a !== 32'hA5) $display("FAIL wr_wd: got %h want a5", wd_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL wr_hreadyout: got %b want 1", hreadyout_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_a !== 1'b0) $display("FAIL wr_we_single: got %b want 0", we_a); else n_pass++;
  endtask

  task automatic test_read;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    n_checks++; if (hreadyout_a !== 1'b0) $display("FAIL rd_wait_ready: got %b want 0", hreadyout_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0) $display("FAIL rd_wait_we: got %b want 0", we_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL rd_done_ready: got %b want 1", hreadyout_a); else n_pass++;
    n_checks++; if (hrdata_a !== 32'h5A) $display("FAIL rd_done_data: got %h want 5a", hrdata_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0) $display("FAIL rd_done_we: got %b want 0", we_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (hrdata_a !== 32'h5A) $display("FAIL rd_hold_data: got %h want 5a", hrdata_a); else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 1'b0, 32'h4, 1'b1, 2'b10, 32'h0);
    drive(1'b1, 1'b0, 32'h8, 1'b1, 2'b10, 32'h11);
    @(negedge clk);
    n_checks++; if (we_a !== 1'b1) $display("FAIL b2b_we0: got %b want 1", we_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h4) $display("FAIL b2b_addr0: got %h want 4", addr_a); else n_pass++;
    n_checks++; if (wd_a !== 32'h11) $display("FAIL b2b_wd0: got %h want 11", wd_a); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h22);
    @(negedge clk);
    n_checks++; if (we_a !== 1'b1) $display("FAIL b2b_we1: got %b want 1", we_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h8) $display("FAIL b2b_addr1: got %h want 8", addr_a); else n_pass++;
    n_checks++; if (wd_a !== 32'h22) $display("FAIL b2b_wd1: got %h want 22", wd_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL b2b_ready: got %b want 1", hreadyout_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_a !== 1'b0) $display("FAIL b2b_we_end: got %b want 0", we_a); else n_pass++;
    n_checks++; if (hrdata_a !== 32'h5A) $display("FAIL b2b_hrdata_kept: got %h want 5a", hrdata_a); else n_pass++;
  endtask

  task automatic test_no_accept;
    drive(1'b1, 1'b0, 32'hC, 1'b1, 2'b01, 32'h0);
    @(negedge clk);
    n_checks++; if (we_a !== 1'b0) $display("FAIL busy_we: got %b want 0", we_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h8) $display("FAIL busy_addr: got %h want 8", addr_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL busy_ready: got %b want 1", hreadyout_a); else n_pass++;
    n_checks++; if (hresp_a !== 1'b0) $display("FAIL busy_hresp: got %b want 0", hresp_a); else n_pass++;
    drive(1'b0, 1'b0, 32'hC, 1'b1, 2'b10, 32'h0);
    @(negedge clk);
    n_checks++; if (we_a !== 1'b0) $display("FAIL nosel_we: got %b want 0", we_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h8) $display("FAIL nosel_addr: got %h want 8", addr_a); else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
  endtask

  task automatic test_reset_mid_read;
    drive(1'b0, 1'b1, 32'h10, 1'b0, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (hreadyout_b !== 1'b0) $display("FAIL rd3_wait%0d: got %b want 0", i, hreadyout_b); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (hreadyout_b !== 1'b1) $display("FAIL rd3_done_ready: got %b want 1", hreadyout_b); else n_pass++;
    n_checks++; if (hrdata_b !== 32'h4A) $display("FAIL rd3_done_data: got %h want 4a", hrdata_b); else n_pass++;
    drive(1'b0, 1'b1, 32'h14, 1'b0, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    n_checks++; if (hreadyout_b !== 1'b0) $display("FAIL rst_pre_ready: got %b want 0", hreadyout_b); else n_pass++;
    #1;
    resetn = 1'b0;
    #1;
    n_checks++; if (hreadyout_b !== 1'b1) $display("FAIL rst_ready: got %b want 1", hreadyout_b); else n_pass++;
    n_checks++; if (hrdata_b !== 32'd0) $display("FAIL rst_hrdata: got %h want 0", hrdata_b); else n_pass++;
    n_checks++; if (we_b !== 1'b0) $display("FAIL rst_we: got %b want 0", we_b); else n_pass++;
    n_checks++; if (addr_b !== 32'd0) $display("FAIL rst_addr: got %h want 0", addr_b); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 1'b1, 32'h20, 1'b1, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h33);
    @(negedge clk);
    n_checks++; if (we_b !== 1'b1) $display("FAIL post_rst_we: got %b want 1", we_b); else n_pass++;
    n_checks++; if (addr_b !== 32'h20) $display("FAIL post_rst_addr: got %h want 20", addr_b); else n_pass++;
    n_checks++; if (wd_b !== 32'h33) $display("FAIL post_rst_wd: got %h want 33", wd_b); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_b !== 1'b0) $display("FAIL post_rst_we_end: got %b want 0", we_b); else n_pass++;
  endtask

  task automatic test_misaligned;
    drive(1'b1, 1'b0, 32'h2, 1'b1, 2'b10, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h77);
    @(negedge clk);
`ifdef AHB2SIMPLE_ERR_EN
    n_checks++; if (hresp_a !== 1'b1) $display("FAIL err1_hresp: got %b want 1", hresp_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b0) $display("FAIL err1_ready: got %b want 0", hreadyout_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0) $display("FAIL err1_we: got %b want 0", we_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (hresp_a !== 1'b1) $display("FAIL err2_hresp: got %b want 1", hresp_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL err2_ready: got %b want 1", hreadyout_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0) $display("FAIL err2_we: got %b want 0", we_a); else n_pass++;
`else
    n_checks++; if (we_a !== 1'b1) $display("FAIL unaligned_we: got %b want 1", we_a); else n_pass++;
    n_checks++; if (hresp_a !== 1'b0) $display("FAIL unaligned_hresp: got %b want 0", hresp_a); else n_pass++;
    n_checks++; if (addr_a !== 32'h2) $display("FAIL unaligned_addr: got %h want 2", addr_a); else n_pass++;
    @(negedge clk);
    n_checks++; if (we_a !== 1'b0) $display("FAIL unaligned_we_end: got %b want 0", we_a); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (hresp_a !== 1'b0) $display("FAIL after_err_hresp: got %b want 0", hresp_a); else n_pass++;
    n_checks++; if (hreadyout_a !== 1'b1) $display("FAIL after_err_ready: got %b want 1", hreadyout_a); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    hsel_a   = 1'b0;
    hsel_b   = 1'b0;
    haddr    = 32'd0;
    hwrite   = 1'b0;
    htrans   = 2'b00;
    hsize    = 3'b010;
    hready   = 1'b1;
    hwdata   = 32'd0;
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_no_accept;
    test_reset_mid_read;
    test_misaligned;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
